fw_tile_feeder: RTL and testbench

Upstream stage of the fw Floyd-Warshall core. It collects N×N distance tiles of W-bit elements, delivered one element per handshake in row-major order, into a two-bank (ping-pong) buffer. It then streams each completed tile to fw as LANES-wide beats, driving fw's inD, in_valid and phase. It honours fw's inhibit back-pressure, so tile loading overlaps streaming.

---
 rtl/fw_tile_feeder.sv | 137 +++++++++++++
 tb/tb_fw_tile_feeder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_tile_feeder.sv
// fw_tile_feeder: ping-pong N x N tile buffer in front of the fw core.
// Tiles load one element per handshake and stream out as LANES-wide beats.
module fw_tile_feeder #(
  parameter int N     = 8,
  parameter int W     = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       ld_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [1:0]         ld_phase,
  output logic [W*LANES-1:0] inD,
  output logic               in_valid,
  output logic [1:0]         phase,
  input  logic               inhibit,
  output logic               tile_done,
  output logic               busy
);

  localparam int NE = N * N;
  localparam int NB = NE / LANES;
  localparam int CW = $clog2(NE);
  localparam int BW = $clog2(NB);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_t;

  bank_t              st     [2];
  bank_t              st_nxt [2];
  logic [W-1:0]       mem    [2][NE];
  logic [1:0]         ptag   [2];
  logic               wr_bank;
  logic               rd_bank;
  logic               pending;
  logic [CW-1:0]      ld_cnt;
  logic [BW-1:0]      beat;

  logic               acc;
  logic               last_el;
  logic               last_beat;
  logic               load_beat;
  logic               rd_sel;
  logic [BW-1:0]      beat_sel;
  logic [W*LANES-1:0] beat_d;

  assign ld_ready  = (st[wr_bank] == EMPTY) ||
                     (st[wr_bank] == FILLING);
  assign acc       = ld_valid && ld_ready;
  assign last_el   = ld_cnt == CW'(NE - 1);
  assign in_valid  = pending && !inhibit;
  assign last_beat = beat == BW'(NB - 1);
  assign tile_done = in_valid && last_beat;
  assign busy      = (st[0] != EMPTY) ||
                     (st[1] != EMPTY) || pending;

  // Load and stream sides never touch the same bank in one cycle:
  // loading owns EMPTY/FILLING, streaming owns FULL/DRAINING.
  always_comb begin
    st_nxt    = st;
    load_beat = 1'b0;
    rd_sel    = rd_bank;
    beat_sel  = '0;
    if (acc) begin
      if (last_el) st_nxt[wr_bank] = FULL;
      else         st_nxt[wr_bank] = FILLING;
    end
    unique case (1'b1)
      (in_valid && !last_beat): begin
        load_beat = 1'b1;
        beat_sel  = beat + 1'b1;
      end
      tile_done: begin
        st_nxt[rd_bank] = EMPTY;
        rd_sel          = ~rd_bank;
        if (st[~rd_bank] == FULL) begin
          load_beat        = 1'b1;
          st_nxt[~rd_bank] = DRAINING;
        end
      end
      (!pending && st[rd_bank] == FULL): begin
        load_beat       = 1'b1;
        st_nxt[rd_bank] = DRAINING;
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_d = '0;
    for (int i = 0; i < LANES; i++)
      beat_d[W*i +: W] =
        mem[rd_sel][CW'(int'(beat_sel) * LANES + i)];
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][ld_cnt] <= ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st[0]   <= EMPTY;
      st[1]   <= EMPTY;
      ptag[0] <= '0;
      ptag[1] <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      pending <= 1'b0;
      ld_cnt  <= '0;
      beat    <= '0;
      inD     <= '0;
      phase   <= '0;
    end else begin
      st      <= st_nxt;
      rd_bank <= rd_sel;
      if (acc) begin
        ld_cnt <= last_el ? '0 : ld_cnt + 1'b1;
        if (last_el) wr_bank <= ~wr_bank;
        if (ld_cnt == '0) ptag[wr_bank] <= ld_phase;
      end
      if (load_beat) begin
        pending <= 1'b1;
        beat    <= beat_sel;
        inD     <= beat_d;
        phase   <= ptag[rd_sel];
      end else if (tile_done) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fw_tile_feeder.sv
// tb_fw_tile_feeder: scoreboard bench for the fw tile feeder.
// Tiles are modelled as element lists; expected beats queue on completion.
module tb_fw_tile_feeder;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] ld_data  = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [1:0]  ld_phase = '0;
  logic [63:0] inD;
  logic        in_valid;
  logic [1:0]  phase;
  logic        inhibit  = 1'b0;
  logic        tile_done;
  logic        busy;

  fw_tile_feeder #(.N(8), .W(16), .LANES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_phase  (ld_phase),
    .inD       (inD),
    .in_valid  (in_valid),
    .phase     (phase),
    .inhibit   (inhibit),
    .tile_done (tile_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  ph;
    logic        last;
  } beat_t;

  beat_t       expq [$];
  beat_t       me;
  logic [15:0] cur  [$];
  logic [1:0]  cur_ph;
  logic [63:0] xlog [$];
  int          xcyc [$];
  logic [1:0]  plog [$];
  int          dlog [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc_cnt = 0;
  int          last_acc_edge = 0;
  logic        rdone = 1'b0;
  logic [15:0] row0 [8] = '{16'h0000, 16'h0054, 16'h0057, 16'h004e,
                            16'h0010, 16'h005e, 16'h0024, 16'h0057};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  // Reference: a tile is 8 rows x 8 cols; beat = (row, column group).
  function automatic void model_accept(logic [15:0] d, logic [1:0] ph);
    beat_t e;
    cur.push_back(d);
    if (cur.size() == 1) cur_ph = ph;
    if (cur.size() == 64) begin
      for (int r = 0; r < 8; r++)
        for (int g = 0; g < 2; g++) begin
          e.d = '0;
          for (int i = 0; i < 4; i++)
            e.d[16*i +: 16] = cur[r*8 + 4*g + i];
          e.ph   = cur_ph;
          e.last = (r == 7) && (g == 1);
          expq.push_back(e);
        end
      cur.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid) begin
        xlog.push_back(inD);
        xcyc.push_back(cyc);
        plog.push_back(phase);
        if (tile_done) dlog.push_back(cyc);
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat got=%h want=none", inD);
        end else begin
          me = expq.pop_front();
          chk("beat_data", inD, me.d);
          chk("beat_phase_done", {61'b0, phase, tile_done},
              {61'b0, me.ph, me.last});
        end
      end else if (tile_done) begin
        total++;
        bad++;
        $display("FAIL done_without_valid got=1 want=0");
      end
    end
  end

  // Called at a rising edge; returns at the edge that takes the last element.
  task automatic load_n(input int n, input logic [1:0] ph,
                        input bit gaps, input bit s1);
    int k = 0;
    int g = 0;
    while (k < n) begin
      #1;
      ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data  = (s1 && cur.size() < 8) ? row0[cur.size()]
                                        : 16'($urandom);
      ld_phase = ph;
      @(negedge clk);
      if (ld_valid && ld_ready) begin
        model_accept(ld_data, ld_phase);
        last_acc_edge = cyc + 1;
        acc_cnt++;
        k++;
      end
      @(posedge clk);
      g++;
      if (g > 4000) begin
        total++;
        bad++;
        $display("FAIL load_timeout got=%0d want=%0d", k, n);
        break;
      end
    end
  endtask

  task automatic ld_stop();
    #1 ld_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((expq.size() != 0 || busy) && g < 2000);
    chk(nm, 64'(expq.size() * 2 + int'(busy)), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    int b, d0, g, a0;
    #2 reset = 1'b0;
    #1;
    chk("rst_inD", inD, 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_tile_done", 64'(tile_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);

    // single tile
    b  = xlog.size();
    d0 = dlog.size();
    load_n(64, 2'b00, 0, 1);
    ld_stop();
    drain("s1_drain");
    chk("s1_beat0", xlog[b], 64'h004e_0057_0054_0000);
    chk("s1_beat1", xlog[b+1], 64'h0057_0024_005e_0010);
    chk("s1_count", 64'(xlog.size() - b), 64'd16);
    chk("s1_done", 64'(dlog.size() - d0), 64'd1);
    chk("s1_latency", 64'(xcyc[b]), 64'(last_acc_edge + 1));

    // inhibit stall on beat 5
    b = xlog.size();
    fork
      begin
        load_n(64, 2'b11, 0, 0);
        ld_stop();
      end
      begin
        g = 0;
        while (xlog.size() - b < 5 && g < 400) begin
          @(posedge clk);
          g++;
        end
        chk("s2_reach_beat5", 64'(xlog.size() - b), 64'd5);
        #1 inhibit = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("s2_stall_valid", 64'(in_valid), 64'd0);
          chk("s2_stall_hold", inD,
              (expq.size() > 0) ? expq[0].d : 64'h0);
        end
        @(posedge clk);
        #1 inhibit = 1'b0;
      end
    join
    drain("s2_drain");
    chk("s2_count", 64'(xlog.size() - b), 64'd16);

    // back-to-back tiles
    b  = xlog.size();
    d0 = dlog.size();
    #1 inhibit = 1'b1;
    @(posedge clk);
    load_n(64, 2'b01, 0, 0);
    load_n(64, 2'b10, 0, 0);
    ld_stop();
    @(posedge clk);
    #1 inhibit = 1'b0;
    drain("s3_drain");
    chk("s3_count", 64'(xlog.size() - b), 64'd32);
    chk("s3_span", 64'(xcyc[b+31] - xcyc[b]), 64'd31);
    chk("s3_phase_first", 64'(plog[b]), 64'd1);
    chk("s3_phase_last", 64'(plog[b+31]), 64'd2);
    chk("s3_done", 64'(dlog.size() - d0), 64'd2);
    chk("s3_done_last", 64'(dlog[d0+1]), 64'(xcyc[b+31]));

    // full back-pressure
    b  = xlog.size();
    a0 = acc_cnt;
    #1 inhibit = 1'b1;
    @(posedge clk);
    fork
      begin
        load_n(192, 2'b00, 0, 0);
        ld_stop();
      end
      begin
        g = 0;
        while (acc_cnt - a0 < 128 && g < 400) begin
          @(posedge clk);
          g++;
        end
        repeat (4) @(negedge clk);
        chk("s4_ready_low", 64'(ld_ready), 64'd0);
        chk("s4_accepted", 64'(acc_cnt - a0), 64'd128);
        @(posedge clk);
        #1 inhibit = 1'b0;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!tile_done && g < 100);
        chk("s4_ready_at_done", 64'({tile_done, ld_ready}), 64'b10);
        @(negedge clk);
        chk("s4_ready_after_done", 64'(ld_ready), 64'd1);
      end
    join
    drain("s4_drain");
    chk("s4_count", 64'(xlog.size() - b), 64'd48);

    // asynchronous reset mid-load
    b = xlog.size();
    load_n(40, 2'b01, 0, 0);
    #1 ld_valid = 1'b0;
    chk("s5_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("s5_in_valid", 64'(in_valid), 64'd0);
    chk("s5_ready", 64'(ld_ready), 64'd1);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_no_beats", 64'(xlog.size() - b), 64'd0);
    cur.delete();
    expq.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    b = xlog.size();
    load_n(64, 2'b00, 0, 1);
    ld_stop();
    drain("s5_drain");
    chk("s5_beat0", xlog[b], 64'h004e_0057_0054_0000);
    chk("s5_beat1", xlog[b+1], 64'h0057_0024_005e_0010);
    chk("s5_count", 64'(xlog.size() - b), 64'd16);

    // last element coincides with last beat
    b = xlog.size();
    #1 inhibit = 1'b1;
    @(posedge clk);
    load_n(127, 2'b10, 0, 0);
    ld_stop();
    @(posedge clk);
    #1 inhibit = 1'b0;
    g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (xlog.size() - b < 15 && g < 100);
    chk("s6_at_beat15", 64'(xlog.size() - b), 64'd15);
    load_n(1, 2'b10, 0, 0);
    #1 ld_valid = 1'b0;
    @(negedge clk);
    chk("s6_idle_gap", 64'({in_valid, busy}), 64'b01);
    @(negedge clk);
    chk("s6_resume", 64'(in_valid), 64'd1);
    chk("s6_coincide", 64'(dlog[dlog.size()-1] + 1), 64'(last_acc_edge));
    drain("s6_drain");
    chk("s6_count", 64'(xlog.size() - b), 64'd32);

    // random gaps and random inhibit
    b = xlog.size();
    fork
      begin
        for (int t = 0; t < 4; t++)
          load_n(64, 2'($urandom), 1, 0);
        ld_stop();
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 inhibit = ($urandom_range(0, 2) == 0);
        end
        inhibit = 1'b0;
      end
    join
    drain("s7_drain");
    chk("s7_count", 64'(xlog.size() - b), 64'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
